// File: rtl/dma_axi64_mem_slave.sv
// AXI3-style 64-bit memory responder for the DMA channel-0 master port.
// Independent write (AW/W/B) and read (AR/R) FSMs share a flop-array memory.
// INCR bursts only; out-of-range beats answer SLVERR.
module dma_axi64_mem_slave #(
    parameter int DEPTH     = 256,
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    // write address
    input  logic [ID_BITS-1:0]   AWID0,
    input  logic [31:0]          AWADDR0,
    input  logic [LEN_BITS-1:0]  AWLEN0,
    input  logic [SIZE_BITS-1:0] AWSIZE0,
    input  logic                 AWVALID0,
    output logic                 AWREADY0,
    // write data
    input  logic [ID_BITS-1:0]   WID0,
    input  logic [63:0]          WDATA0,
    input  logic [7:0]           WSTRB0,
    input  logic                 WLAST0,
    input  logic                 WVALID0,
    output logic                 WREADY0,
    // write response
    output logic [ID_BITS-1:0]   BID0,
    output logic [1:0]           BRESP0,
    output logic                 BVALID0,
    input  logic                 BREADY0,
    // read address
    input  logic [ID_BITS-1:0]   ARID0,
    input  logic [31:0]          ARADDR0,
    input  logic [LEN_BITS-1:0]  ARLEN0,
    input  logic [SIZE_BITS-1:0] ARSIZE0,
    input  logic                 ARVALID0,
    output logic                 ARREADY0,
    // read data
    output logic [ID_BITS-1:0]   RID0,
    output logic [63:0]          RDATA0,
    output logic [1:0]           RRESP0,
    output logic                 RLAST0,
    output logic                 RVALID0,
    input  logic                 RREADY0,
    // status
    output logic                 idle
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic R_IDLE = 1'b0;
    localparam logic R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Bytes per beat for a given size code.
    function automatic logic [31:0] beat_bytes(input logic [SIZE_BITS-1:0] s);
        return 32'd1 << s;
    endfunction

    // Start address aligned down to the beat size.
    function automatic logic [31:0] align_addr(input logic [31:0] a,
                                               input logic [SIZE_BITS-1:0] s);
        return a & ~(beat_bytes(s) - 32'd1);
    endfunction

    logic [63:0] mem_q [DEPTH];

    // Ready/idle stay low during reset and for the reset edge itself.
    logic rst_done_q, rst_done_d;

    // ---------------- write path state ----------------
    logic [1:0]           w_state_q, w_state_d;
    logic [ID_BITS-1:0]   w_id_q,    w_id_d;
    logic [31:0]          w_addr_q,  w_addr_d;
    logic [SIZE_BITS-1:0] w_size_q,  w_size_d;
    logic [LEN_BITS-1:0]  w_len_q,   w_len_d;
    logic [LEN_BITS-1:0]  w_cnt_q,   w_cnt_d;
    logic                 w_err_q,   w_err_d;

    logic                 w_in_range;
    logic                 w_last;
    logic                 mem_we;
    logic [AW-1:0]        mem_widx;

    // ---------------- read path state ----------------
    logic                 r_state_q, r_state_d;
    logic [ID_BITS-1:0]   r_id_q,    r_id_d;
    logic [31:0]          r_addr_q,  r_addr_d;
    logic [SIZE_BITS-1:0] r_size_q,  r_size_d;
    logic [LEN_BITS-1:0]  r_len_q,   r_len_d;
    logic [LEN_BITS-1:0]  r_cnt_q,   r_cnt_d;
    logic [63:0]          rdata_q,   rdata_d;
    logic [1:0]           rresp_q,   rresp_d;
    logic                 rlast_q,   rlast_d;

    logic [31:0]          rd_addr;
    logic                 rd_in_range;
    logic [63:0]          rd_word;

    // ---------------- outputs ----------------
    assign AWREADY0 = rst_done_q && (w_state_q == W_IDLE);
    assign WREADY0  = (w_state_q == W_DATA);
    assign BVALID0  = (w_state_q == W_RESP);
    assign BID0     = w_id_q;
    assign BRESP0   = w_err_q ? RESP_SLVERR : RESP_OKAY;

    assign ARREADY0 = rst_done_q && (r_state_q == R_IDLE);
    assign RVALID0  = (r_state_q == R_DATA);
    assign RID0     = r_id_q;
    assign RDATA0   = rdata_q;
    assign RRESP0   = rresp_q;
    assign RLAST0   = rlast_q;

    assign idle = rst_done_q && (w_state_q == W_IDLE) && (r_state_q == R_IDLE);

    assign rst_done_d = 1'b1;

    // Current write beat decode: word index, range check, final-beat flag.
    assign w_in_range = (w_addr_q[31:AW+3] == '0);
    assign mem_widx   = w_addr_q[AW+2:3];
    assign w_last     = (w_cnt_q == w_len_q);

    // Write FSM next-state: capture AW, consume W beats, hold B until taken.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_size_d  = w_size_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID0 && AWREADY0) begin
                    w_id_d    = AWID0;
                    w_addr_d  = align_addr(AWADDR0, AWSIZE0);
                    w_size_d  = AWSIZE0;
                    w_len_d   = AWLEN0;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID0) begin
                    // Out-of-range beats are dropped but still counted.
                    if (w_in_range) mem_we = 1'b1;
                    else            w_err_d = 1'b1;
                    // Termination follows AWLEN; WLAST only flags a mismatch.
                    if (WLAST0 != w_last) w_err_d = 1'b1;
                    w_addr_d = w_addr_q + beat_bytes(w_size_q);
                    w_cnt_d  = w_cnt_q + 1'b1;
                    if (w_last) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY0) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read address to fetch this cycle: burst start when idle, next beat otherwise.
    always_comb begin
        rd_addr = align_addr(ARADDR0, ARSIZE0);
        if (r_state_q == R_DATA) rd_addr = r_addr_q + beat_bytes(r_size_q);
    end

    // Memory read mux; out-of-range words read as zero.
    assign rd_in_range = (rd_addr[31:AW+3] == '0);
    assign rd_word     = rd_in_range ? mem_q[rd_addr[AW+2:3]] : 64'd0;

    // Read FSM next-state: load beat 0 on AR, advance on each non-last R handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_size_d  = r_size_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID0 && ARREADY0) begin
                    r_id_d    = ARID0;
                    r_addr_d  = rd_addr;
                    r_size_d  = ARSIZE0;
                    r_len_d   = ARLEN0;
                    r_cnt_d   = '0;
                    rdata_d   = rd_word;
                    rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rlast_d   = (ARLEN0 == '0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY0) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = rd_addr;
                        r_cnt_d  = r_cnt_q + 1'b1;
                        rdata_d  = rd_word;
                        rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rlast_d  = (LEN_BITS'(r_cnt_q + 1'b1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control/state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rst_done_q <= 1'b0;
            w_state_q  <= W_IDLE;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_size_q   <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_err_q    <= 1'b0;
            r_state_q  <= R_IDLE;
            r_id_q     <= '0;
            r_addr_q   <= '0;
            r_size_q   <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            rst_done_q <= rst_done_d;
            w_state_q  <= w_state_d;
            w_id_q     <= w_id_d;
            w_addr_q   <= w_addr_d;
            w_size_q   <= w_size_d;
            w_len_q    <= w_len_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            r_id_q     <= r_id_d;
            r_addr_q   <= r_addr_d;
            r_size_q   <= r_size_d;
            r_len_q    <= r_len_d;
            r_cnt_q    <= r_cnt_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
        end
    end

    // Byte-enabled memory write; contents survive reset, no write on a reset edge.
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (WSTRB0[b]) mem_q[mem_widx][8*b +: 8] <= WDATA0[8*b +: 8];
            end
        end
    end

    // WID is not checked and the sub-word address bits do not select a word.
    logic unused_bits;
    assign unused_bits = ^{WID0, rd_addr[2:0]};

endmodule

// File: tb/tb_dma_axi64_mem_slave.sv
// Directed bench for dma_axi64_mem_slave: tables of write bursts and read
// bursts with hand-computed expectations, plus reset and concurrency sequences.
module tb_dma_axi64_mem_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  AWID0 = '0;
    logic [31:0] AWADDR0 = '0;
    logic [3:0]  AWLEN0 = '0;
    logic [1:0]  AWSIZE0 = '0;
    logic        AWVALID0 = 1'b0;
    logic        AWREADY0;
    logic [3:0]  WID0 = '0;
    logic [63:0] WDATA0 = '0;
    logic [7:0]  WSTRB0 = '0;
    logic        WLAST0 = 1'b0;
    logic        WVALID0 = 1'b0;
    logic        WREADY0;
    logic [3:0]  BID0;
    logic [1:0]  BRESP0;
    logic        BVALID0;
    logic        BREADY0 = 1'b0;
    logic [3:0]  ARID0 = '0;
    logic [31:0] ARADDR0 = '0;
    logic [3:0]  ARLEN0 = '0;
    logic [1:0]  ARSIZE0 = '0;
    logic        ARVALID0 = 1'b0;
    logic        ARREADY0;
    logic [3:0]  RID0;
    logic [63:0] RDATA0;
    logic [1:0]  RRESP0;
    logic        RLAST0;
    logic        RVALID0;
    logic        RREADY0 = 1'b0;
    logic        idle;

    always #5 clk = ~clk;

    dma_axi64_mem_slave dut (
        .clk(clk), .reset(reset),
        .AWID0(AWID0), .AWADDR0(AWADDR0), .AWLEN0(AWLEN0), .AWSIZE0(AWSIZE0),
        .AWVALID0(AWVALID0), .AWREADY0(AWREADY0),
        .WID0(WID0), .WDATA0(WDATA0), .WSTRB0(WSTRB0), .WLAST0(WLAST0),
        .WVALID0(WVALID0), .WREADY0(WREADY0),
        .BID0(BID0), .BRESP0(BRESP0), .BVALID0(BVALID0), .BREADY0(BREADY0),
        .ARID0(ARID0), .ARADDR0(ARADDR0), .ARLEN0(ARLEN0), .ARSIZE0(ARSIZE0),
        .ARVALID0(ARVALID0), .ARREADY0(ARREADY0),
        .RID0(RID0), .RDATA0(RDATA0), .RRESP0(RRESP0), .RLAST0(RLAST0),
        .RVALID0(RVALID0), .RREADY0(RREADY0),
        .idle(idle)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [1:0]       size;
        int               wlast_at;
        int               bdelay;
        logic [1:0]       bresp;
        logic [7:0][63:0] wd;
        logic [7:0][7:0]  ws;
    } wvec_t;

    typedef struct {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [1:0]       size;
        bit               stall;
        logic [7:0][63:0] rd;
        logic [7:0][1:0]  rr;
    } rvec_t;

    function automatic wvec_t mkw(input logic [3:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [1:0] size,
                                  input int wlast_at, input int bdelay,
                                  input logic [1:0] bresp);
        wvec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size;
        v.wlast_at = wlast_at; v.bdelay = bdelay; v.bresp = bresp;
        v.wd = '0; v.ws = '0;
        return v;
    endfunction

    function automatic rvec_t mkr(input logic [3:0] id, input logic [31:0] addr,
                                  input logic [3:0] len, input logic [1:0] size,
                                  input bit stall);
        rvec_t v;
        v.id = id; v.addr = addr; v.len = len; v.size = size; v.stall = stall;
        v.rd = '0; v.rr = '0;
        return v;
    endfunction

    // Full write burst: AW, len+1 back-to-back W beats, B held for bdelay cycles.
    task automatic do_write(input wvec_t v, input string nm);
        int to;
        AWID0 = v.id; AWADDR0 = v.addr; AWLEN0 = v.len; AWSIZE0 = v.size;
        AWVALID0 = 1'b1;
        to = 0;
        while (AWREADY0 !== 1'b1 && to < 20) begin @(posedge clk); #1; to++; end
        chk({nm, "_awready"}, 64'(AWREADY0), 64'd1);
        @(posedge clk); #1;
        AWVALID0 = 1'b0;
        for (int i = 0; i <= int'(v.len); i++) begin
            WDATA0 = v.wd[i]; WSTRB0 = v.ws[i];
            WLAST0 = (i == v.wlast_at); WVALID0 = 1'b1;
            chk($sformatf("%s_wready_b%0d", nm, i), 64'(WREADY0), 64'd1);
            @(posedge clk); #1;
        end
        WVALID0 = 1'b0; WLAST0 = 1'b0;
        for (int d = 0; d < v.bdelay; d++) begin
            chk($sformatf("%s_bvalid_hold%0d", nm, d), 64'(BVALID0), 64'd1);
            chk($sformatf("%s_bresp_hold%0d", nm, d), 64'(BRESP0), 64'(v.bresp));
            @(posedge clk); #1;
        end
        BREADY0 = 1'b1;
        chk({nm, "_bvalid"}, 64'(BVALID0), 64'd1);
        chk({nm, "_bid"}, 64'(BID0), 64'(v.id));
        chk({nm, "_bresp"}, 64'(BRESP0), 64'(v.bresp));
        @(posedge clk); #1;
        BREADY0 = 1'b0;
        chk({nm, "_bvalid_drop"}, 64'(BVALID0), 64'd0);
    endtask

    // Full read burst; with stall set RREADY follows 1,0,0,1 and every
    // stalled cycle re-checks the held beat.
    task automatic do_read(input rvec_t v, input string nm);
        int to;
        int b;
        int cyc;
        logic rr;
        ARID0 = v.id; ARADDR0 = v.addr; ARLEN0 = v.len; ARSIZE0 = v.size;
        ARVALID0 = 1'b1;
        to = 0;
        while (ARREADY0 !== 1'b1 && to < 20) begin @(posedge clk); #1; to++; end
        chk({nm, "_arready"}, 64'(ARREADY0), 64'd1);
        @(posedge clk); #1;
        ARVALID0 = 1'b0;
        b = 0; cyc = 0;
        while (b <= int'(v.len) && cyc < 64) begin
            rr = v.stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            RREADY0 = rr;
            chk($sformatf("%s_rvalid_b%0d", nm, b), 64'(RVALID0), 64'd1);
            chk($sformatf("%s_rdata_b%0d", nm, b), RDATA0, v.rd[b]);
            chk($sformatf("%s_rresp_b%0d", nm, b), 64'(RRESP0), 64'(v.rr[b]));
            chk($sformatf("%s_rlast_b%0d", nm, b), 64'(RLAST0), 64'(b == int'(v.len)));
            chk($sformatf("%s_rid_b%0d", nm, b), 64'(RID0), 64'(v.id));
            @(posedge clk); #1;
            cyc++;
            if (rr) b++;
        end
        chk({nm, "_cycle_budget"}, 64'(b), 64'(int'(v.len) + 1));
        RREADY0 = 1'b0;
        chk({nm, "_rvalid_drop"}, 64'(RVALID0), 64'd0);
    endtask

    wvec_t wv[8];
    rvec_t rv[7];

    initial begin
        // ---- vector tables ----
        wv[0] = mkw(4'd3, 32'h40, 4'd3, 2'd3, 3, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            wv[0].wd[i] = 64'h11 * 64'(i + 1); wv[0].ws[i] = 8'hFF;
        end
        wv[1] = mkw(4'd1, 32'h8, 4'd0, 2'd3, 0, 0, 2'b00);
        wv[1].wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; wv[1].ws[0] = 8'hFF;
        wv[2] = mkw(4'd2, 32'h8, 4'd0, 2'd3, 0, 0, 2'b00);
        wv[2].wd[0] = 64'hAAAA_AAAA_BBBB_BBBB; wv[2].ws[0] = 8'h0F;
        wv[3] = mkw(4'd5, 32'h7F8, 4'd1, 2'd3, 1, 0, 2'b10);
        wv[3].wd[0] = 64'h55; wv[3].ws[0] = 8'hFF;
        wv[3].wd[1] = 64'h66; wv[3].ws[1] = 8'hFF;
        wv[4] = mkw(4'd6, 32'h100, 4'd3, 2'd3, 2, 1, 2'b10);
        for (int i = 0; i < 4; i++) begin
            wv[4].wd[i] = 64'hA1 + 64'(i); wv[4].ws[i] = 8'hFF;
        end
        wv[5] = mkw(4'd7, 32'h203, 4'd1, 2'd2, 1, 0, 2'b00);
        wv[5].wd[0] = 64'h1111_1111_2222_2222; wv[5].ws[0] = 8'h0F;
        wv[5].wd[1] = 64'h3333_3333_4444_4444; wv[5].ws[1] = 8'hF0;
        wv[6] = mkw(4'd8, 32'h400, 4'd7, 2'd3, 7, 0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            wv[6].wd[i] = 64'hC0 + 64'(i); wv[6].ws[i] = 8'hFF;
        end
        wv[7] = mkw(4'd9, 32'h600, 4'd1, 2'd3, 1, 3, 2'b00);
        wv[7].wd[0] = 64'hD0; wv[7].ws[0] = 8'hFF;
        wv[7].wd[1] = 64'hD1; wv[7].ws[1] = 8'hFF;

        rv[0] = mkr(4'd3, 32'h40, 4'd3, 2'd3, 1'b0);
        for (int i = 0; i < 4; i++) rv[0].rd[i] = 64'h11 * 64'(i + 1);
        rv[1] = mkr(4'd2, 32'h8, 4'd0, 2'd3, 1'b0);
        rv[1].rd[0] = 64'hFFFF_FFFF_BBBB_BBBB;
        rv[2] = mkr(4'd5, 32'h7F8, 4'd1, 2'd3, 1'b0);
        rv[2].rd[0] = 64'h55; rv[2].rd[1] = 64'h0; rv[2].rr[1] = 2'b10;
        rv[3] = mkr(4'd6, 32'h100, 4'd3, 2'd3, 1'b0);
        for (int i = 0; i < 4; i++) rv[3].rd[i] = 64'hA1 + 64'(i);
        rv[4] = mkr(4'd7, 32'h203, 4'd1, 2'd2, 1'b0);
        rv[4].rd[0] = 64'h3333_3333_2222_2222; rv[4].rd[1] = 64'h3333_3333_2222_2222;
        rv[5] = mkr(4'd8, 32'h400, 4'd7, 2'd3, 1'b1);
        for (int i = 0; i < 8; i++) rv[5].rd[i] = 64'hC0 + 64'(i);
        rv[6] = mkr(4'd9, 32'h600, 4'd1, 2'd3, 1'b0);
        rv[6].rd[0] = 64'hD0; rv[6].rd[1] = 64'hD1;

        // ---- reset state ----
        @(posedge clk); @(posedge clk); #1;
        chk("rst_awready", 64'(AWREADY0), 64'd0);
        chk("rst_wready", 64'(WREADY0), 64'd0);
        chk("rst_bvalid", 64'(BVALID0), 64'd0);
        chk("rst_bresp_bid", 64'({BRESP0, BID0}), 64'd0);
        chk("rst_arready", 64'(ARREADY0), 64'd0);
        chk("rst_rvalid", 64'(RVALID0), 64'd0);
        chk("rst_r_fields", 64'({RLAST0, RRESP0, RID0}), 64'd0);
        chk("rst_rdata", RDATA0, 64'd0);
        chk("rst_idle", 64'(idle), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_awready", 64'(AWREADY0), 64'd1);
        chk("rel_arready", 64'(ARREADY0), 64'd1);
        chk("rel_idle", 64'(idle), 64'd1);

        // ---- table-driven bursts ----
        for (int i = 0; i < 6; i++) do_write(wv[i], $sformatf("w%0d", i));
        for (int i = 0; i < 5; i++) do_read(rv[i], $sformatf("r%0d", i));

        // ---- stalled read running alongside a write with delayed BREADY ----
        do_write(wv[6], "w6");
        fork
            do_read(rv[5], "r5_stall");
            do_write(wv[7], "w7_conc");
        join
        do_read(rv[6], "r6");
        chk("idle_after", 64'(idle), 64'd1);

        // ---- reset in the middle of a read burst ----
        ARID0 = 4'd8; ARADDR0 = 32'h400; ARLEN0 = 4'd7; ARSIZE0 = 2'd3;
        ARVALID0 = 1'b1; RREADY0 = 1'b1;
        @(posedge clk); #1;
        ARVALID0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst_beat2", RDATA0, 64'hC2);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_rvalid", 64'(RVALID0), 64'd0);
        chk("midrst_rlast", 64'(RLAST0), 64'd0);
        chk("midrst_idle", 64'(idle), 64'd0);
        reset = 1'b1; RREADY0 = 1'b0;
        @(posedge clk); #1;
        chk("midrst_arready", 64'(ARREADY0), 64'd1);
        chk("midrst_idle_rel", 64'(idle), 64'd1);

        // Memory written before reset is still there.
        do_read(rv[0], "r0_retain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_axi64_mem_slave.md
# dma_axi64_mem_slave

AXI3-style 64-bit memory responder forming the far end of the DMA core's AXI master port (AW/W/B/AR/R channel 0). It accepts INCR write and read bursts, stores data in an internal flop array, and returns B and R responses. It lets the DMA serializing wrapper run closed-loop in simulation and on silicon, without an external interconnect. Write and read paths are independent and run concurrently.

## Interface
- DEPTH, 256, number of 64-bit memory words; power of two, 2..4096
- ID_BITS, 4, width of all AXI ID fields
- LEN_BITS, 4, burst length field width (beats = LEN+1)
- SIZE_BITS, 2, burst size field width (bytes/beat = 1<<SIZE, SIZE ≤ 3)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- AWID0  in  ID_BITS  write burst ID
- AWADDR0  in  32  write start byte address
- AWLEN0  in  LEN_BITS  write beats minus one
- AWSIZE0  in  SIZE_BITS  write beat size
- AWVALID0 / AWREADY0  in / out  1  write address handshake
- WID0  in  ID_BITS  write data ID (ignored)
- WDATA0  in  64  write data
- WSTRB0  in  8  byte enables
- WLAST0  in  1  last write beat marker
- WVALID0 / WREADY0  in / out  1  write data handshake
- BID0  out  ID_BITS  response ID (= captured AWID0)
- BRESP0  out  2  00 OKAY, 10 SLVERR
- BVALID0 / BREADY0  out / in  1  write response handshake
- ARID0  in  ID_BITS  read burst ID
- ARADDR0, ARLEN0, ARSIZE0  in  32 / LEN_BITS / SIZE_BITS  read burst descriptor
- ARVALID0 / ARREADY0  in / out  1  read address handshake
- RID0  out  ID_BITS  read ID (= captured ARID0)
- RDATA0  out  64  read data
- RRESP0  out  2  00 OKAY, 10 SLVERR
- RLAST0  out  1  last read beat
- RVALID0 / RREADY0  out / in  1  read data handshake
- idle  out  1  both FSMs in IDLE

## Operation
- Write FSM: W_IDLE (AWREADY0=1) -> AW handshake -> W_DATA (WREADY0=1). Captures ID, addr aligned down to 1<<size, size, beat count = AWLEN0+1, and clears the error flag.
- W_DATA: each W handshake writes the WSTRB0-enabled bytes to mem[addr[31:3]] and adds 1<<size to addr. On the final beat (counter reaches LEN+1) -> W_RESP. WLAST0 is ignored for termination.
- W_RESP: BVALID0=1 and BRESP0 held stable until BREADY0 -> W_IDLE.
- Write error flag, sets BRESP0=SLVERR: set by any beat with addr[31:3] ≥ DEPTH (that beat's write is suppressed), and by a WLAST0 value that mismatches the final-beat position.
- Read FSM: R_IDLE (ARREADY0=1) -> AR handshake -> R_DATA. At the handshake edge, RDATA0 loads mem[idx0]; RID0, RRESP0 and RLAST0 (= ARLEN0==0) are set.
- R_DATA: RVALID0=1. Each R handshake that is not last loads the next beat (addr += 1<<size). A handshake with RLAST0=1 -> R_IDLE.
- Out-of-range read beat: RDATA0=0, RRESP0=SLVERR for that beat only.
- Narrow sizes: the full 64-bit word is returned. Address arithmetic is 32-bit and wraps modulo 2^32. No 4KB boundary check.
- Only INCR bursts; burst type is not decoded. Memory contents are not reset.

## Timing
- Reset (reset=0 at an edge) values: AWREADY0=0, WREADY0=0, BVALID0=0, BRESP0=0, BID0=0, ARREADY0=0, RVALID0=0, RLAST0=0, RRESP0=0, RID0=0, RDATA0=0, idle=0.
- First cycle after reset release: AWREADY0=1, ARREADY0=1, idle=1.
- Reset mid-burst aborts both FSMs with no response issued; memory writes already completed are retained.
- Write latency: AW accepted at edge T -> WREADY0=1 from T+1. Last W at edge T2 -> BVALID0 at T2+1.
- Read latency: AR accepted at edge T -> RVALID0 with beat 0 at T+1. Back-to-back beats are possible every cycle while RREADY0=1.
- Minimum gap between bursts on the same path is one IDLE cycle: AWREADY0/ARREADY0 are 0 while busy.
- A write and a read to the same word on the same edge: the read loads pre-write data.
- R outputs hold stable while RVALID0=1 && RREADY0=0. B outputs hold stable while BVALID0=1 && BREADY0=0.

## Test plan
- Reset, then AW{id=3, addr=0x40, len=3, size=3} with 4 W beats 0x11..0x44 (strb=FF, WLAST on beat 4) -> BID0=3, BRESP0=00. Then AR same -> RDATA0 0x11,0x22,0x33,0x44 on consecutive cycles, RLAST0 on beat 4, RID0=3.
- Write addr=0x8, WSTRB0=0x0F, data=0xAAAA_AAAA_BBBB_BBBB over an old word of all ones -> read returns 0xFFFF_FFFF_BBBB_BBBB.
- DEPTH=256: write len=1 at addr=0x7F8 -> beat 0 stored, beat 1 (word 256) dropped, BRESP0=10. Read the same range -> RRESP0 00 then 10, second RDATA0=0.
- Read len=7 with RREADY0 toggled 1,0,0,1 repeating -> all 8 beats delivered in order, outputs stable while stalled. Concurrently, a write burst completes with BVALID0 held 3 cycles until BREADY0.
- len=3 write with WLAST0 asserted on beat 2 -> 4 beats consumed, BRESP0=10.
- Assert reset=0 mid read burst (beat 2 of 8) -> next cycle RVALID0=0, RLAST0=0. After release, ARREADY0=1 and idle=1.
